// File: rtl/axis_frame_arb.sv
// ----------------------------------------------------------------------------
// axis_frame_arb
//
// Frame-granular AXI-Stream arbiter. Shares one AXI-Stream output between
// S_COUNT sources. A grant is taken on a frame's first beat and held until
// that frame's tlast beat is accepted, so frames never interleave. Accepted
// beats pass through a two-entry skid stage (main + temp) for full throughput.
// The source index of every beat is reported on m_axis_tid.
//
// Build option:
//   AXIS_FRAME_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration
//                                  undefined -> fixed priority (port 0 highest)
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   s_axis_*       S_COUNT packed source streams (port i at slice i)
//   m_axis_*       merged output stream, m_axis_tid = source index
//   grant_valid    a frame grant is active
//   grant_index    currently granted port
// ----------------------------------------------------------------------------
module axis_frame_arb #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1,
    parameter int SEL_WIDTH   = $clog2(S_COUNT)
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [S_COUNT*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [S_COUNT-1:0]               s_axis_tvalid,
    output logic [S_COUNT-1:0]               s_axis_tready,
    input  logic [S_COUNT-1:0]               s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0]    s_axis_tuser,

    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [SEL_WIDTH-1:0]             m_axis_tid,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,

    output logic                             grant_valid,
    output logic [SEL_WIDTH-1:0]             grant_index
);

    // One beat as stored in the skid stage: {data, keep, last, id, user}
    localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + SEL_WIDTH + USER_WIDTH;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic                    grant_valid_reg, grant_valid_next;
    logic [SEL_WIDTH-1:0]    grant_index_reg, grant_index_next;

    logic                    req_found;
    logic [SEL_WIDTH-1:0]    req_sel;

    logic                    m_valid_reg, m_valid_next;
    logic                    temp_valid_reg, temp_valid_next;
    logic                    skid_in_ready_reg;
    logic [BEAT_WIDTH-1:0]   main_beat_reg;
    logic [BEAT_WIDTH-1:0]   temp_beat_reg;
    logic                    load_main_from_in;
    logic                    load_main_from_temp;
    logic                    load_temp;

    logic                    beat_accept;
    logic                    beat_last;
    logic [BEAT_WIDTH-1:0]   in_beat;

    // Per-port views of the packed source buses
    logic [DATA_WIDTH-1:0]   in_data [S_COUNT];
    logic [KEEP_WIDTH-1:0]   in_keep [S_COUNT];
    logic [USER_WIDTH-1:0]   in_user [S_COUNT];

    generate
        for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_port
            assign in_data[gi] = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
            // Without keep support every lane is reported valid.
            assign in_keep[gi] = (KEEP_ENABLE != 0) ? s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH]
                                                    : {KEEP_WIDTH{1'b1}};
            assign in_user[gi] = s_axis_tuser[gi*USER_WIDTH +: USER_WIDTH];
            // Only the granted port sees ready, and only while temp is empty.
            assign s_axis_tready[gi] = (state_reg == ACTIVE)
                                    && (grant_index_reg == SEL_WIDTH'(gi))
                                    && skid_in_ready_reg;
        end
    endgenerate

    assign beat_accept = (state_reg == ACTIVE) && s_axis_tvalid[grant_index_reg] && skid_in_ready_reg;
    assign beat_last   = s_axis_tlast[grant_index_reg];
    assign in_beat     = {in_data[grant_index_reg], in_keep[grant_index_reg], beat_last,
                          grant_index_reg, in_user[grant_index_reg]};

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef AXIS_FRAME_ARB_ROUND_ROBIN_EN
    logic [SEL_WIDTH-1:0]    last_g_reg, last_g_next;

    // Search last_g+1, last_g+2, ... (mod S_COUNT). The loop runs from the
    // farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        req_found = |s_axis_tvalid;
        req_sel   = '0;
        for (int k = S_COUNT; k >= 1; k--) begin
            int idx;
            idx = int'(last_g_reg) + k;
            if (idx >= S_COUNT) begin
                idx = idx - S_COUNT;
            end
            if (s_axis_tvalid[idx]) begin
                req_sel = SEL_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_g_reg <= SEL_WIDTH'(S_COUNT - 1);
        end else begin
            last_g_reg <= last_g_next;
        end
    end
`else
    // Fixed priority: lowest-index requester wins.
    always_comb begin
        req_found = |s_axis_tvalid;
        req_sel   = '0;
        for (int k = S_COUNT - 1; k >= 0; k--) begin
            if (s_axis_tvalid[k]) begin
                req_sel = SEL_WIDTH'(k);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        grant_valid_next = grant_valid_reg;
        grant_index_next = grant_index_reg;
`ifdef AXIS_FRAME_ARB_ROUND_ROBIN_EN
        last_g_next      = last_g_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (req_found) begin
                    state_next       = ACTIVE;
                    grant_valid_next = 1'b1;
                    grant_index_next = req_sel;
                end
            end
            ACTIVE: begin
                // Grant is released only by an accepted tlast beat; a
                // mid-frame tvalid gap simply holds the grant.
                if (beat_accept && beat_last) begin
                    state_next       = IDLE;
                    grant_valid_next = 1'b0;
`ifdef AXIS_FRAME_ARB_ROUND_ROBIN_EN
                    last_g_next      = grant_index_reg;
`endif
                end
            end
            default: begin
                state_next       = IDLE;
                grant_valid_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Skid stage control
    // ------------------------------------------------------------------
    always_comb begin
        m_valid_next        = m_valid_reg;
        temp_valid_next     = temp_valid_reg;
        load_main_from_in   = 1'b0;
        load_main_from_temp = 1'b0;
        load_temp           = 1'b0;
        if (!m_valid_reg || m_axis_tready) begin
            // Main is empty or draining this cycle.
            if (temp_valid_reg) begin
                // Input is blocked while temp is full, so only temp moves.
                m_valid_next        = 1'b1;
                temp_valid_next     = 1'b0;
                load_main_from_temp = 1'b1;
            end else begin
                m_valid_next      = beat_accept;
                load_main_from_in = beat_accept;
            end
        end else if (beat_accept) begin
            // Main is full and stalled: park the beat in temp.
            temp_valid_next = 1'b1;
            load_temp       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= IDLE;
            grant_valid_reg   <= 1'b0;
            grant_index_reg   <= '0;
            m_valid_reg       <= 1'b0;
            temp_valid_reg    <= 1'b0;
            skid_in_ready_reg <= 1'b1;
        end else begin
            state_reg         <= state_next;
            grant_valid_reg   <= grant_valid_next;
            grant_index_reg   <= grant_index_next;
            m_valid_reg       <= m_valid_next;
            temp_valid_reg    <= temp_valid_next;
            skid_in_ready_reg <= !temp_valid_next;
        end
    end

    // Data path registers carry no reset; their valids qualify them.
    always_ff @(posedge clk) begin
        if (load_main_from_temp) begin
            main_beat_reg <= temp_beat_reg;
        end else if (load_main_from_in) begin
            main_beat_reg <= in_beat;
        end
        if (load_temp) begin
            temp_beat_reg <= in_beat;
        end
    end

    assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tuser} = main_beat_reg;
    assign m_axis_tvalid = m_valid_reg;
    assign grant_valid   = grant_valid_reg;
    assign grant_index   = grant_index_reg;

endmodule
